pattern_detect_scheduler: RTL and testbench

//  - Shares one pattern_detector_pulse instance (4-bit nibble, match on 4'b1000, 1-cycle registered pulse) among NUM_REQ requesters.
//  - Each requester submits a nibble over a valid/ready handshake. The block arbitrates round-robin, sequences the detector and returns a per-requester match result.
//  - Keeps a saturating match counter per requester. Sits between the nibble sources and the status/CSR logic.

---
 rtl/pds_pkg.sv | 17 +
 rtl/pattern_detector_pulse.sv | 29 ++
 rtl/pds_rr_arbiter.sv | 39 +++
 rtl/pattern_detect_scheduler.sv | 159 +++++++++++++++
 tb/tb_pattern_detect_scheduler.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/pds_pkg.sv
// Package for the pattern detect scheduler slice.
// Holds the FSM state encoding, the nibble width and the detector pattern.
// The pattern is listed here for reference only. pattern_detector_pulse owns the value it actually matches.
package pds_pkg;

    localparam int NIBBLE_W = 4;

    // Reference copy of the detector pattern. It is not used for matching.
    localparam logic [NIBBLE_W-1:0] PATTERN = 4'b1000;

    // Scheduler FSM state encoding (2-bit).
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/pattern_detector_pulse.sv
// Nibble pattern detector that produces a single-cycle registered match pulse.
// Ports:
//   clk          in   1         clock
//   reset        in   1         synchronous, active-high
//   enable       in   1         a nibble is presented this cycle
//   data_in      in   NIBBLE_W  nibble under test
//   match_pulse  out  1         high for one cycle, the cycle after an enabled match
module pattern_detector_pulse
    import pds_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NIBBLE_W-1:0] data_in,
    output logic                match_pulse
);

    localparam logic [NIBBLE_W-1:0] DETECT_PATTERN = 4'b1000;

    // Register the compare so the pulse lands exactly one cycle after enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_pulse <= 1'b0;
        end else begin
            match_pulse <= enable && (data_in == DETECT_PATTERN);
        end
    end

endmodule

// File: rtl/pds_rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req        in   NUM_REQ  request vector
//   ptr        in   ID_W     index holding highest priority in this pick
//   grant      out  NUM_REQ  one-hot grant, or zero when nothing requests
//   grant_idx  out  ID_W     index of the granted requester
//   any        out  1        at least one request is present
module pds_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any
);

    int cand_s;

    // Search upward from ptr and wrap at NUM_REQ-1. The first asserted index wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand_s    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                grant_idx     = ID_W'(cand_s);
                any           = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/pattern_detect_scheduler.sv
// Shares one pattern_detector_pulse among NUM_REQ requesters.
// Requests are arbitrated round-robin. Each granted request is run through the detector.
// The result is returned to the requester on a per-requester valid/ready response.
// The block also keeps one saturating match counter per requester.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   req_valid    in   NUM_REQ        nibble pending per requester
//   req_data     in   4*NUM_REQ      nibble of requester i at [4*i+:4]
//   req_ready    out  NUM_REQ        one-hot accept strobe, only in IDLE
//   rsp_valid    out  NUM_REQ        one-hot result pending
//   rsp_match    out  1              result bit
//   rsp_ready    in   NUM_REQ        result consumed (only the served index counts)
//   clr_counts   in   1              synchronous clear of all match counters
//   match_count  out  CNT_W*NUM_REQ  saturating counter i at [CNT_W*i+:CNT_W]
//   busy         out  1              FSM is not in IDLE
//   grant_id     out  ID_W           requester currently being served
module pattern_detect_scheduler
    import pds_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NIBBLE_W*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic                         rsp_match,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    input  logic                         clr_counts,
    output logic [CNT_W*NUM_REQ-1:0]     match_count,
    output logic                         busy,
    output logic [ID_W-1:0]              grant_id
);

    logic [1:0]                      state_r;
    logic [ID_W-1:0]                 ptr_r;
    logic [ID_W-1:0]                 id_r;
    logic [NIBBLE_W-1:0]             data_r;
    logic [NUM_REQ-1:0]              rsp_valid_r;
    logic                            rsp_match_r;
    logic [NUM_REQ-1:0][CNT_W-1:0]   cnt_r;

    logic [NUM_REQ-1:0]              arb_gnt_s;
    logic [ID_W-1:0]                 arb_idx_s;
    logic                            arb_any_s;
    logic                            accept_s;
    logic [NIBBLE_W-1:0]             sel_data_s;
    logic                            det_en_s;
    logic                            det_pulse_s;
    logic [ID_W-1:0]                 ptr_next_s;

    // Increment a counter, holding it at its maximum value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    pds_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_r),
        .grant     (arb_gnt_s),
        .grant_idx (arb_idx_s),
        .any       (arb_any_s)
    );

    pattern_detector_pulse u_det (
        .clk         (clk),
        .reset       (reset),
        .enable      (det_en_s),
        .data_in     (data_r),
        .match_pulse (det_pulse_s)
    );

    // Accept only in IDLE. While reset is asserted nothing may see a ready.
    assign accept_s  = (state_r == ST_IDLE) && !reset && arb_any_s;
    assign req_ready = accept_s ? arb_gnt_s : '0;
    assign det_en_s  = (state_r == ST_ISSUE);
    assign ptr_next_s = (id_r == ID_W'(NUM_REQ - 1)) ? '0 : id_r + ID_W'(1);

    // Select the granted requester's nibble by AND-OR over the one-hot grant.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_data_s = sel_data_s
                       | (req_data[i*NIBBLE_W +: NIBBLE_W] & {NIBBLE_W{arb_gnt_s[i]}});
        end
    end

    // Scheduler FSM: latch request, drive detector, capture result, hold response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ptr_r       <= '0;
            id_r        <= '0;
            data_r      <= '0;
            rsp_valid_r <= '0;
            rsp_match_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        id_r    <= arb_idx_s;
                        data_r  <= sel_data_s;
                        state_r <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // The detector pulse for the ISSUE cycle is visible now.
                    rsp_match_r <= det_pulse_s;
                    rsp_valid_r <= {{(NUM_REQ-1){1'b0}}, 1'b1} << id_r;
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready[id_r]) begin
                        rsp_valid_r <= '0;
                        ptr_r       <= ptr_next_s;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= '0;
                end
            endcase
        end
    end

    // Per-requester saturating match counters. A clear takes priority over an increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (clr_counts) begin
            cnt_r <= '0;
        end else if ((state_r == ST_WAIT) && det_pulse_s) begin
            cnt_r[id_r] <= sat_inc(cnt_r[id_r]);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign rsp_valid   = rsp_valid_r;
    assign rsp_match   = rsp_match_r;
    assign match_count = cnt_r;
    assign busy        = (state_r != ST_IDLE);
    assign grant_id    = id_r;

endmodule

// File: tb/tb_pattern_detect_scheduler.sv
// Directed bench for pattern_detect_scheduler (NUM_REQ=4, CNT_W=2).
// The bench computes the expected grant from its own round-robin pointer.
// At acceptance it pushes the expected response. The entry is popped when rsp_valid rises.
// The bench tracks its own saturating counters.
module tb_pattern_detect_scheduler;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    typedef struct {
        int   id;
        logic m;
    } sb_t;

    logic                     clk;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [4*NUM_REQ-1:0]     req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic                     rsp_match;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic                     clr_counts;
    logic [CNT_W*NUM_REQ-1:0] match_count;
    logic                     busy;
    logic [1:0]               grant_id;

    int  n_checks = 0;
    int  n_err    = 0;
    int  m_ptr    = 0;
    int  m_cnt[NUM_REQ];
    sb_t sb[$];

    pattern_detect_scheduler #(
        .NUM_REQ (NUM_REQ),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_match   (rsp_match),
        .rsp_ready   (rsp_ready),
        .clr_counts  (clr_counts),
        .match_count (match_count),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_REQ-1:0] onehot(input int id);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    function automatic int model_pick(input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
        end
        return 0;
    endfunction

    function automatic logic [CNT_W*NUM_REQ-1:0] model_counts();
        logic [CNT_W*NUM_REQ-1:0] v;
        for (int i = 0; i < NUM_REQ; i++) v[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
    endtask

    // One full transaction: accept (T), ISSUE, WAIT, RESP (T+3), optional hold, back to IDLE.
    task automatic transact(input logic [NUM_REQ-1:0] valid, input logic [4*NUM_REQ-1:0] data,
                            input int hold, input logic keep, input logic clr_in_wait);
        sb_t e;
        sb_t got;
        logic [3:0] nib;
        logic       sv_match;
        req_valid = valid;
        req_data  = data;
        #1;
        e.id = model_pick(valid);
        nib  = data[e.id*4 +: 4];
        e.m  = (nib == 4'h8);
        check("accept_ready", 32'(req_ready), 32'(onehot(e.id)));
        check("accept_busy", 32'(busy), 32'd0);
        sb.push_back(e);
        rsp_ready = (hold == 0) ? 4'hF : ~onehot(e.id);
        tick();
        if (!keep) req_valid = '0;
        check("issue_busy", 32'(busy), 32'd1);
        check("issue_ready", 32'(req_ready), 32'd0);
        check("issue_gid", 32'(grant_id), 32'(e.id));
        check("issue_rspv", 32'(rsp_valid), 32'd0);
        tick();
        check("wait_rspv", 32'(rsp_valid), 32'd0);
        check("wait_ready", 32'(req_ready), 32'd0);
        clr_counts = clr_in_wait;
        tick();
        clr_counts = 1'b0;
        if (clr_in_wait) begin
            for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
        end else if (e.m && m_cnt[e.id] < CNT_MAX) begin
            m_cnt[e.id]++;
        end
        check("resp_counts", 32'(match_count), 32'(model_counts()));
        check("resp_gid", 32'(grant_id), 32'(e.id));
        check("resp_present", 32'(rsp_valid != '0), 32'd1);
        got = sb.pop_front();
        check("resp_valid", 32'(rsp_valid), 32'(onehot(got.id)));
        check("resp_match", 32'(rsp_match), 32'(got.m));
        sv_match = rsp_match;
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", 32'(rsp_valid), 32'(onehot(got.id)));
            check("hold_match", 32'(rsp_match), 32'(sv_match));
            check("hold_ready", 32'(req_ready), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
        end
        rsp_ready = onehot(got.id);
        tick();
        m_ptr = (got.id + 1) % NUM_REQ;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_rspv", 32'(rsp_valid), 32'd0);
        rsp_ready = '0;
    endtask

    initial begin
        sb_t dropped;
        reset      = 1'b1;
        req_valid  = 4'hF;
        req_data   = 16'h8888;
        rsp_ready  = '0;
        clr_counts = 1'b0;
        model_reset();
        tick();
        tick();
        // Reset state, with every requester asking during reset.
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rspv", 32'(rsp_valid), 32'd0);
        check("rst_match", 32'(rsp_match), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        check("rst_counts", 32'(match_count), 32'd0);
        reset     = 1'b0;
        req_valid = '0;
        tick();

        // Single matching request from requester 1.
        transact(4'b0010, 16'h0080, 0, 1'b0, 1'b0);
        // Non-matching request from requester 0.
        transact(4'b0001, 16'h0009, 0, 1'b0, 1'b0);
        // Non-matching request from requester 3, which also brings the pointer back to 0.
        transact(4'b1000, 16'h1000, 0, 1'b0, 1'b0);

        // Round robin: all valid, back to back. Expected grants are 0,1,2,3,0.
        for (int g = 0; g < 5; g++) begin
            transact(4'hF, 16'h8898, 0, 1'b1, 1'b0);
        end
        req_valid = '0;
        tick();

        // Backpressure on requester 2 while requester 3 keeps asking.
        transact(4'b1100, 16'h0800, 10, 1'b1, 1'b0);
        req_valid = '0;
        tick();

        // Saturation of requester 3 at 3 with CNT_W=2.
        for (int s = 0; s < 5; s++) begin
            transact(4'b1000, 16'h8000, 0, 1'b0, 1'b0);
        end
        check("sat_count3", 32'(match_count[3*CNT_W +: CNT_W]), 32'd3);

        // Clear in the same cycle as a WAIT-state match. The clear wins.
        transact(4'b1000, 16'h8000, 0, 1'b0, 1'b1);
        check("clr_count3", 32'(match_count[3*CNT_W +: CNT_W]), 32'd0);

        // Make a counter non-zero, then reset during WAIT.
        transact(4'b0001, 16'h0008, 0, 1'b0, 1'b0);
        req_valid = 4'b0001;
        req_data  = 16'h0008;
        #1;
        check("rw_ready", 32'(req_ready), 32'(onehot(model_pick(4'b0001))));
        dropped.id = model_pick(4'b0001);
        dropped.m  = 1'b1;
        sb.push_back(dropped);
        tick();
        req_valid = '0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        // The request in flight at reset is dropped and never gets a response.
        sb.delete();
        model_reset();
        check("rw_busy", 32'(busy), 32'd0);
        check("rw_rspv", 32'(rsp_valid), 32'd0);
        check("rw_counts", 32'(match_count), 32'd0);
        check("rw_gid", 32'(grant_id), 32'd0);
        tick();
        tick();
        check("rw_quiet", 32'(rsp_valid), 32'd0);
        // After reset the lowest valid index gets the next grant.
        transact(4'b1010, 16'h8080, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
